kbd_ser: RTL

KBD_SER -- requirements
Module: kbd_ser

---
 rtl/kbd_ser.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/kbd_ser.sv
// Serialises a 4x10 key matrix as 13-bit change frames to a downstream matrix CPLD.
// Optional periodic full refresh is enabled by defining KBD_SER_REFRESH_EN.
module kbd_ser #(
    parameter int DIV         = 4,
    parameter int REFRESH_CYC = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [39:0] matrix,
    output logic        sclk,
    output logic        sdata,
    output logic        scs,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

    localparam logic [7:0] DIV_M1 = 8'(DIV - 1);

    state_t          state_q, state_d;
    logic [3:0]      bitCnt_q, bitCnt_d;
    logic [7:0]      divCnt_q, divCnt_d;
    logic            phase_q, phase_d;
    logic [12:0]     shift_q, shift_d;
    logic [1:0]      grp_q, grp_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [9:0]      snap_q, snap_d;
    logic [3:0][9:0] shadow_q, shadow_d;
    logic [3:0]      valid_q, valid_d;

    logic [3:0][9:0] slice;
    logic [3:0]      pend;
    logic            anyPend;
    logic [1:0]      pick;
    logic [1:0]      idx;
    logic            refreshHit;

    assign slice = matrix;

`ifdef KBD_SER_REFRESH_EN
    logic [23:0] refCnt_q;

    always_ff @(posedge clk) begin
        if (rst || refreshHit) begin
            refCnt_q <= '0;
        end else begin
            refCnt_q <= refCnt_q + 24'd1;
        end
    end

    assign refreshHit = (refCnt_q == 24'(REFRESH_CYC - 1));
`else
    assign refreshHit = 1'b0;
`endif

    // Descending scan so the pending group closest to ptr wins.
    always_comb begin
        anyPend = 1'b0;
        pick    = ptr_q;
        idx     = ptr_q;
        for (int g = 0; g < 4; g++) begin
            pend[g] = !valid_q[g] || (slice[g] != shadow_q[g]);
        end
        for (int i = 3; i >= 0; i--) begin
            idx = ptr_q + 2'(i);
            if (pend[idx]) begin
                pick    = idx;
                anyPend = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        bitCnt_d = bitCnt_q;
        divCnt_d = divCnt_q;
        phase_d  = phase_q;
        shift_d  = shift_q;
        grp_d    = grp_q;
        ptr_d    = ptr_q;
        snap_d   = snap_q;
        shadow_d = shadow_q;
        valid_d  = valid_q;
        case (state_q)
            IDLE: begin
                if (anyPend) begin
                    grp_d    = pick;
                    ptr_d    = pick + 2'd1;
                    snap_d   = slice[pick];
                    shift_d  = {1'b0, pick, ~slice[pick]};
                    bitCnt_d = 4'd12;
                    divCnt_d = DIV_M1;
                    phase_d  = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (divCnt_q != 8'd0) begin
                    divCnt_d = divCnt_q - 8'd1;
                end else begin
                    divCnt_d = DIV_M1;
                    if (phase_q) begin
                        phase_d = 1'b0;
                    end else begin
                        phase_d = 1'b1;
                        if (bitCnt_q == 4'd0) begin
                            state_d = HOLD;
                        end else begin
                            bitCnt_d = bitCnt_q - 4'd1;
                            shift_d  = {shift_q[11:0], 1'b1};
                        end
                    end
                end
            end
            HOLD: begin
                if (divCnt_q != 8'd0) begin
                    divCnt_d = divCnt_q - 8'd1;
                end else begin
                    divCnt_d         = DIV_M1;
                    state_d          = GAP;
                    shadow_d[grp_q]  = snap_q;
                    valid_d[grp_q]   = 1'b1;
                end
            end
            GAP: begin
                if (divCnt_q != 8'd0) begin
                    divCnt_d = divCnt_q - 8'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A refresh outranks a same-cycle commit so that group is still resent.
        if (refreshHit) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            bitCnt_q <= '0;
            divCnt_q <= '0;
            phase_q  <= 1'b1;
            shift_q  <= '1;
            grp_q    <= '0;
            ptr_q    <= '0;
            snap_q   <= '1;
            shadow_q <= '1;
            valid_q  <= '0;
        end else begin
            state_q  <= state_d;
            bitCnt_q <= bitCnt_d;
            divCnt_q <= divCnt_d;
            phase_q  <= phase_d;
            shift_q  <= shift_d;
            grp_q    <= grp_d;
            ptr_q    <= ptr_d;
            snap_q   <= snap_d;
            shadow_q <= shadow_d;
            valid_q  <= valid_d;
        end
    end

    assign scs   = !((state_q == SHIFT) || (state_q == HOLD));
    assign sclk  = (state_q == SHIFT) ? phase_q : 1'b1;
    assign sdata = ((state_q == SHIFT) || (state_q == HOLD)) ? shift_q[12] : 1'b1;
    assign busy  = (state_q != IDLE);

endmodule
